// File: rtl/seq_trojan_trigger.sv
// seq_trojan_trigger
// Watches a data bus for an ordered sequence of DEPTH patterns. Consecutive
// matched beats must be separated by fewer than MAX_GAP invalid cycles. Once
// the sequence has completed THRESHOLD times, the registered trigger fires.
//
// Optional build macro: TRIG_AUTOCLEAR_EN
//   undefined : FIRED is sticky until rst.
//   defined   : Tj_Trig stays high for HOLD cycles, then the detector clears
//               seq_count and re-arms.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   state_valid  qualifies state for this cycle
//   state        observed bus, W bits
//   Tj_Trig      registered trigger
//   match_idx    index of the next expected pattern
//   seq_count    saturating count of completed sequences
module seq_trojan_trigger #(
  parameter int unsigned W         = 128,
  parameter int unsigned DEPTH     = 2,
  parameter logic [DEPTH*W-1:0] PATTERNS = '0,
  parameter int unsigned MAX_GAP   = 8,
  parameter int unsigned THRESHOLD = 1,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned HOLD      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         state_valid,
  input  logic [W-1:0]                 state,
  output logic                         Tj_Trig,
  output logic [$clog2(DEPTH+1)-1:0]   match_idx,
  output logic [CNT_W-1:0]             seq_count
);

  localparam int IDX_W = $clog2(DEPTH + 1);
  localparam int GAP_W = $clog2(MAX_GAP + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MATCHING = 2'd1,
    FIRED    = 2'd2
  } fsm_t;

  fsm_t             fsm_q, fsm_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             trig_q;

`ifdef TRIG_AUTOCLEAR_EN
  localparam int HOLD_W = $clog2(HOLD + 1);
  logic [HOLD_W-1:0] hold_q, hold_d;
`endif

  // Unpack the flat pattern vector into one entry per sequence step.
  logic [W-1:0] pat [DEPTH];
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_pat
      assign pat[gi] = PATTERNS[gi*W +: W];
    end
  endgenerate

  logic [W-1:0]     cur_pat;
  logic             hit_cur;
  logic             hit_first;
  logic [CNT_W-1:0] cnt_inc;
  logic [GAP_W-1:0] gap_inc;

  always_comb begin
    cur_pat = pat[0];
    for (int k = 0; k < DEPTH; k++) begin
      if (idx_q == IDX_W'(k)) cur_pat = pat[k];
    end
  end

  assign hit_cur   = (state == cur_pat);
  assign hit_first = (state == pat[0]);
  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign gap_inc   = gap_q + 1'b1;

  always_comb begin
    fsm_d = fsm_q;
    idx_d = idx_q;
    gap_d = gap_q;
    cnt_d = cnt_q;
`ifdef TRIG_AUTOCLEAR_EN
    hold_d = hold_q;
`endif
    if (fsm_q == FIRED) begin
`ifdef TRIG_AUTOCLEAR_EN
      // Last hold cycle: drop the trigger and re-arm from scratch.
      if (hold_q <= HOLD_W'(1)) begin
        fsm_d  = IDLE;
        idx_d  = '0;
        gap_d  = '0;
        cnt_d  = '0;
        hold_d = '0;
      end else begin
        hold_d = hold_q - 1'b1;
      end
`endif
    end else if (state_valid) begin
      if (hit_cur) begin
        gap_d = '0;
        if (idx_q == IDX_W'(DEPTH - 1)) begin
          idx_d = '0;
          cnt_d = cnt_inc;
          if (cnt_inc >= CNT_W'(THRESHOLD)) begin
            fsm_d = FIRED;
`ifdef TRIG_AUTOCLEAR_EN
            hold_d = HOLD_W'(HOLD);
`endif
          end else begin
            fsm_d = IDLE;
          end
        end else begin
          idx_d = idx_q + 1'b1;
          fsm_d = MATCHING;
        end
      end else if (fsm_q == MATCHING) begin
        // A mismatching beat may itself be the start of a new sequence.
        gap_d = '0;
        if (hit_first) begin
          idx_d = IDX_W'(1);
          fsm_d = MATCHING;
        end else begin
          idx_d = '0;
          fsm_d = IDLE;
        end
      end
    end else if (fsm_q == MATCHING) begin
      if (gap_inc == GAP_W'(MAX_GAP)) begin
        idx_d = '0;
        gap_d = '0;
        fsm_d = IDLE;
      end else begin
        gap_d = gap_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q  <= IDLE;
      idx_q  <= '0;
      gap_q  <= '0;
      cnt_q  <= '0;
      trig_q <= 1'b0;
`ifdef TRIG_AUTOCLEAR_EN
      hold_q <= '0;
`endif
    end else begin
      fsm_q  <= fsm_d;
      idx_q  <= idx_d;
      gap_q  <= gap_d;
      cnt_q  <= cnt_d;
      trig_q <= (fsm_d == FIRED);
`ifdef TRIG_AUTOCLEAR_EN
      hold_q <= hold_d;
`endif
    end
  end

  assign Tj_Trig   = trig_q;
  assign match_idx = idx_q;
  assign seq_count = cnt_q;

endmodule

// File: tb/tb_seq_trojan_trigger.sv
module tb_seq_trojan_trigger;

  localparam logic [127:0] P0 = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] P1 = 128'hffeeddcc_bbaa9988_77665544_33221100;

  logic         clk;
  logic         rst;
  logic         state_valid;
  logic [127:0] state;

  // dut_a: THRESHOLD=1, dut_b: THRESHOLD=3, dut_c: DEPTH=1, THRESHOLD=2
  logic       a_trig, b_trig, c_trig;
  logic [1:0] a_idx, b_idx;
  logic [0:0] c_idx;
  logic [7:0] a_cnt, b_cnt;
  logic [1:0] c_cnt;

  logic [10:0] a_obs, b_obs;
  logic [3:0]  c_obs;
  assign a_obs = {a_trig, a_idx, a_cnt};
  assign b_obs = {b_trig, b_idx, b_cnt};
  assign c_obs = {c_trig, c_idx, c_cnt};

  int checks = 0;
  int errors = 0;

  seq_trojan_trigger #(
    .W(128), .DEPTH(2), .PATTERNS({P1, P0}), .MAX_GAP(4),
    .THRESHOLD(1), .CNT_W(8), .HOLD(5)
  ) dut_a (
    .clk(clk), .rst(rst), .state_valid(state_valid), .state(state),
    .Tj_Trig(a_trig), .match_idx(a_idx), .seq_count(a_cnt)
  );

  seq_trojan_trigger #(
    .W(128), .DEPTH(2), .PATTERNS({P1, P0}), .MAX_GAP(4),
    .THRESHOLD(3), .CNT_W(8), .HOLD(5)
  ) dut_b (
    .clk(clk), .rst(rst), .state_valid(state_valid), .state(state),
    .Tj_Trig(b_trig), .match_idx(b_idx), .seq_count(b_cnt)
  );

  seq_trojan_trigger #(
    .W(128), .DEPTH(1), .PATTERNS(P0), .MAX_GAP(4),
    .THRESHOLD(2), .CNT_W(2), .HOLD(5)
  ) dut_c (
    .clk(clk), .rst(rst), .state_valid(state_valid), .state(state),
    .Tj_Trig(c_trig), .match_idx(c_idx), .seq_count(c_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One beat: drive inputs, take the edge, settle 1 time unit past it.
  task automatic step(input logic v, input logic [127:0] d);
    state_valid = v;
    state       = d;
    @(posedge clk);
    #1;
    $display("beat valid=%0b data=%h | a trig=%0b idx=%0d cnt=%0d | b trig=%0b idx=%0d cnt=%0d | c trig=%0b cnt=%0d",
             v, d, a_trig, a_idx, a_cnt, b_trig, b_idx, b_cnt, c_trig, c_cnt);
  endtask

  task automatic do_reset();
    state_valid = 1'b0;
    state       = '0;
    rst         = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    state_valid = 1'b1;
    state = P0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({a_obs, b_obs, c_obs} !== 26'd0) begin
      errors++;
      $display("FAIL reset got a=%h b=%h c=%h want all 0", a_obs, b_obs, c_obs);
    end
    state_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    step(1'b1, P0);
    checks++;
    if (a_obs !== {1'b0, 2'd1, 8'd0}) begin
      errors++; $display("FAIL basic_p0 got %h want %h", a_obs, {1'b0, 2'd1, 8'd0});
    end
    step(1'b1, P1);
    checks++;
    if (a_obs !== {1'b1, 2'd0, 8'd1}) begin
      errors++; $display("FAIL basic_p1 got %h want %h", a_obs, {1'b1, 2'd0, 8'd1});
    end
`ifndef TRIG_AUTOCLEAR_EN
    // Sticky and frozen while fired.
    step(1'b1, P0);
    step(1'b0, '0);
    repeat (6) step(1'b0, '0);
    step(1'b1, P0);
    step(1'b1, P1);
    checks++;
    if (a_obs !== {1'b1, 2'd0, 8'd1}) begin
      errors++; $display("FAIL basic_sticky got %h want %h", a_obs, {1'b1, 2'd0, 8'd1});
    end
`endif
  endtask

  task automatic test_gap_timeout();
    do_reset();
    step(1'b1, P0);
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, P1);
      checks++;
      if (a_obs !== {1'b0, (i == 4) ? 2'd0 : 2'd1, 8'd0}) begin
        errors++; $display("FAIL gap_invalid%0d got %h want idx %0d", i, a_obs, (i == 4) ? 0 : 1);
      end
    end
    step(1'b1, P1);
    checks++;
    if (a_obs !== {1'b0, 2'd0, 8'd0}) begin
      errors++; $display("FAIL gap_late_p1 got %h want %h", a_obs, {1'b0, 2'd0, 8'd0});
    end
    do_reset();
    step(1'b1, P0);
    repeat (3) step(1'b0, '0);
    checks++;
    if (a_obs !== {1'b0, 2'd1, 8'd0}) begin
      errors++; $display("FAIL gap_3inv got %h want %h", a_obs, {1'b0, 2'd1, 8'd0});
    end
    step(1'b1, P1);
    checks++;
    if (a_obs !== {1'b1, 2'd0, 8'd1}) begin
      errors++; $display("FAIL gap_fire got %h want %h", a_obs, {1'b1, 2'd0, 8'd1});
    end
  endtask

  task automatic test_mismatch_restart();
    do_reset();
    step(1'b1, P0);
    step(1'b1, P0);
    checks++;
    if (a_obs !== {1'b0, 2'd1, 8'd0}) begin
      errors++; $display("FAIL restart_p0p0 got %h want %h", a_obs, {1'b0, 2'd1, 8'd0});
    end
    step(1'b1, P1);
    checks++;
    if (a_obs !== {1'b1, 2'd0, 8'd1}) begin
      errors++; $display("FAIL restart_fire got %h want %h", a_obs, {1'b1, 2'd0, 8'd1});
    end
    do_reset();
    step(1'b1, P0);
    step(1'b1, '0);
    checks++;
    if (a_obs !== {1'b0, 2'd0, 8'd0}) begin
      errors++; $display("FAIL restart_zero got %h want %h", a_obs, {1'b0, 2'd0, 8'd0});
    end
    step(1'b1, P1);
    checks++;
    if (a_obs !== {1'b0, 2'd0, 8'd0}) begin
      errors++; $display("FAIL restart_nofire got %h want %h", a_obs, {1'b0, 2'd0, 8'd0});
    end
  endtask

  task automatic test_threshold();
    do_reset();
    for (int r = 1; r <= 3; r++) begin
      step(1'b1, P0);
      checks++;
      if (b_obs !== {1'b0, 2'd1, 8'(r - 1)}) begin
        errors++; $display("FAIL thr_p0_run%0d got %h want %h", r, b_obs, {1'b0, 2'd1, 8'(r - 1)});
      end
      step(1'b1, P1);
      checks++;
      if (b_obs !== {(r == 3), 2'd0, 8'(r)}) begin
        errors++; $display("FAIL thr_p1_run%0d got %h want %h", r, b_obs, {(r == 3), 2'd0, 8'(r)});
      end
    end
    step(1'b1, P0);
    step(1'b1, P1);
    checks++;
    if (b_obs !== {1'b1, 2'd0, 8'd3}) begin
      errors++; $display("FAIL thr_frozen got %h want %h", b_obs, {1'b1, 2'd0, 8'd3});
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1'b1, P0);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (a_obs !== 11'd0) begin
      errors++; $display("FAIL async_mid got %h want 0", a_obs);
    end
    rst = 1'b0;
    step(1'b1, P0);
    step(1'b1, P1);
    checks++;
    if (a_obs !== {1'b1, 2'd0, 8'd1}) begin
      errors++; $display("FAIL async_refire got %h want %h", a_obs, {1'b1, 2'd0, 8'd1});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (a_obs !== 11'd0) begin
      errors++; $display("FAIL async_fired got %h want 0", a_obs);
    end
    rst = 1'b0;
  endtask

  task automatic test_depth1();
    do_reset();
    step(1'b1, P1);
    checks++;
    if (c_obs !== 4'b0_0_00) begin
      errors++; $display("FAIL d1_miss got %h want 0", c_obs);
    end
    step(1'b1, P0);
    checks++;
    if (c_obs !== 4'b0_0_01) begin
      errors++; $display("FAIL d1_first got %h want 1", c_obs);
    end
    repeat (5) step(1'b0, '0);
    step(1'b1, P0);
    checks++;
    if (c_obs !== 4'b1_0_10) begin
      errors++; $display("FAIL d1_fire got %h want a", c_obs);
    end
    step(1'b1, P0);
    checks++;
    if (c_obs !== 4'b1_0_10) begin
      errors++; $display("FAIL d1_frozen got %h want a", c_obs);
    end
  endtask

`ifdef TRIG_AUTOCLEAR_EN
  task automatic test_autoclear();
    do_reset();
    step(1'b1, P0);
    step(1'b1, P1);
    for (int i = 2; i <= 6; i++) begin
      // Beats during the hold must be ignored.
      if (i == 3) step(1'b1, P0);
      else if (i == 4) step(1'b1, P1);
      else step(1'b0, '0);
      checks++;
      if (a_obs !== ((i <= 5) ? {1'b1, 2'd0, 8'd1} : 11'd0)) begin
        errors++; $display("FAIL autoclear_cycle%0d got %h", i, a_obs);
      end
    end
    step(1'b1, P0);
    step(1'b1, P1);
    checks++;
    if (a_obs !== {1'b1, 2'd0, 8'd1}) begin
      errors++; $display("FAIL autoclear_refire got %h want %h", a_obs, {1'b1, 2'd0, 8'd1});
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    state_valid = 1'b0;
    state = '0;
    test_reset();
    test_basic();
    test_gap_timeout();
    test_mismatch_restart();
    test_threshold();
    test_async_reset();
    test_depth1();
`ifdef TRIG_AUTOCLEAR_EN
    test_autoclear();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
